// File: rtl/key_filter_pkg.sv
// Shared types and constants for the key debounce filter.
//   state_t      : FSM state encoding used by key_filter
//   SYNC_RST_VAL : level the input synchronizer resets to (key released)
package key_filter_pkg;

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      PRESSED      = 2'd2,
      RELEASE_WAIT = 2'd3
   } state_t;

   localparam logic SYNC_RST_VAL = 1'b1;

endpackage

// File: rtl/key_filter_sync.sv
// Two-flop synchronizer for the raw asynchronous key level.
// Ports:
//   clk   : system clock
//   rst_n : synchronous reset, active-high; both stages load SYNC_RST_VAL
//   d     : asynchronous input level
//   q     : synchronized level, two clk edges behind d
module key_sync
   import key_filter_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;

   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         meta_q <= SYNC_RST_VAL;
         sync_q <= SYNC_RST_VAL;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/key_filter.sv
// Debounce filter for an active-low mechanical key. Emits one single-cycle
// active-low click per qualified press; releases never click.
// Ports:
//   clk     : system clock
//   rst_n   : synchronous reset, active-high (1 = reset)
//   key_n   : raw key level, active-low, asynchronous, may bounce
//   click_n : registered active-low click strobe, one cycle per press
//
// state        | meaning
// -------------+---------------------------------------------
// IDLE         | key released, armed for the next press
// PRESS_WAIT   | key seen low, counting toward qualification
// PRESSED      | press qualified and clicked, key held
// RELEASE_WAIT | key seen high, counting toward release
module key_filter
   import key_filter_pkg::*;
#(
   parameter int unsigned MASK_TIME = 1000000
)(
   input  logic clk,
   input  logic rst_n,
   input  logic key_n,
   output logic click_n
);

   localparam int unsigned CNT_W = $clog2(MASK_TIME) + 1;
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   // The counter holds the number of qualifying samples seen so far; the
   // sample that would bring it to MASK_TIME performs the transition, so
   // the stored value stays at or below MASK_TIME - 1 and never wraps.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MASK_TIME - 1);

   logic             key_s;
   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             click_q, click_d;

   key_sync u_key_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (key_n),
      .q     (key_s)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      click_d = 1'b1;
      case (state_q)
         IDLE: begin
            if (!key_s) begin
               state_d = PRESS_WAIT;
               cnt_d   = CNT_ONE;
            end else begin
               cnt_d   = '0;
            end
         end
         PRESS_WAIT: begin
            if (key_s) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q >= CNT_LAST) begin
               state_d = PRESSED;
               cnt_d   = '0;
               click_d = 1'b0;
            end else begin
               cnt_d   = cnt_q + CNT_ONE;
            end
         end
         PRESSED: begin
            if (key_s) begin
               state_d = RELEASE_WAIT;
               cnt_d   = CNT_ONE;
            end else begin
               cnt_d   = '0;
            end
         end
         RELEASE_WAIT: begin
            if (!key_s) begin
               state_d = PRESSED;
               cnt_d   = '0;
            end else if (cnt_q >= CNT_LAST) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d   = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         click_q <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         click_q <= click_d;
      end
   end

   assign click_n = click_q;

endmodule

// File: tb/tb_key_filter.sv
// Bench for key_filter with MASK_TIME = 5 and a 20 ns clock. A run-length
// reference model predicts click_n every cycle; directed scenarios add click
// counts and latency checks, followed by a randomized key/reset phase.
// Key and reset edges land at 5 mod 10 ns, never on a rising clk edge.
module tb_key_filter;

   localparam int M = 5;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   logic key_n = 1'b1;
   logic click_n;

   int errors = 0;
   int checks = 0;

   int cyc            = 0;
   int dut_clicks     = 0;
   int last_click_cyc = -1000;

   logic m_s1 = 1'b1;
   logic m_s2 = 1'b1;
   logic ks;
   bit   m_pressed = 1'b0;
   int   m_run     = 0;
   logic exp_click = 1'b1;
   int   m_clicks  = 0;

   key_filter #(.MASK_TIME(M)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .key_n   (key_n),
      .click_n (click_n)
   );

   always #10 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference: a press qualifies after M consecutive low synchronized samples
   // while released; a release after M consecutive high samples while pressed.
   always @(posedge clk) begin
      cyc++;
      if (rst_n) begin
         m_s1      = 1'b1;
         m_s2      = 1'b1;
         m_pressed = 1'b0;
         m_run     = 0;
         exp_click = 1'b1;
      end else begin
         ks        = m_s2;
         m_s2      = m_s1;
         m_s1      = key_n;
         exp_click = 1'b1;
         if (!m_pressed) begin
            m_run = ks ? 0 : m_run + 1;
            if (m_run == M) begin
               m_pressed = 1'b1;
               m_run     = 0;
               exp_click = 1'b0;
               m_clicks++;
            end
         end else begin
            m_run = ks ? m_run + 1 : 0;
            if (m_run == M) begin
               m_pressed = 1'b0;
               m_run     = 0;
            end
         end
      end
   end

   always @(negedge clk) begin
      check_eq("click", {31'b0, click_n}, {31'b0, exp_click});
      check_eq("cnt_bound", {31'b0, (dut.cnt_q <= M)}, 32'd1);
      if (click_n === 1'b0) begin
         dut_clicks++;
         last_click_cyc = cyc;
      end
   end

   initial begin
      int c0, cf;
      #205;
      rst_n = 1'b0;
      check_eq("reset_click", {31'b0, click_n}, 32'd1);
      check_eq("reset_cnt", {28'b0, dut.cnt_q}, 32'd0);

      // short glitches only
      c0 = dut_clicks;
      key_n = 1'b0; #10; key_n = 1'b1; #20; key_n = 1'b0; #80; key_n = 1'b1;
      #400;
      check_eq("glitch_clicks", dut_clicks - c0, 32'd0);

      // clean press with latency
      c0 = dut_clicks; cf = cyc;
      key_n = 1'b0; #400; key_n = 1'b1; #400;
      check_eq("press_clicks", dut_clicks - c0, 32'd1);
      check_eq("press_latency", last_click_cyc - cf, 32'd7);

      // press then bouncy release
      c0 = dut_clicks;
      key_n = 1'b0; #400;
      check_eq("bounce_press", dut_clicks - c0, 32'd1);
      c0 = dut_clicks;
      key_n = 1'b1; #10; key_n = 1'b0; #20; key_n = 1'b1; #80;
      key_n = 1'b0; #200; key_n = 1'b1; #400;
      check_eq("bounce_release", dut_clicks - c0, 32'd0);

      // long hold
      c0 = dut_clicks;
      key_n = 1'b0; #2000; key_n = 1'b1; #400;
      check_eq("hold_clicks", dut_clicks - c0, 32'd1);

      // reset during PRESS_WAIT, key still held
      c0 = dut_clicks;
      key_n = 1'b0; #100;
      rst_n = 1'b1; #100;
      check_eq("rst_abort", dut_clicks - c0, 32'd0);
      cf = cyc;
      rst_n = 1'b0; #400;
      check_eq("rst_requal", dut_clicks - c0, 32'd1);
      check_eq("rst_latency", last_click_cyc - cf, 32'd7);
      key_n = 1'b1; #400;

      // two clean presses
      c0 = dut_clicks;
      for (int i = 0; i < 2; i++) begin
         key_n = 1'b0; #200; key_n = 1'b1; #200;
      end
      check_eq("two_clicks", dut_clicks - c0, 32'd2);

      // randomized key levels and occasional resets
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 24) == 0) begin
            rst_n = 1'b1; #20; rst_n = 1'b0;
         end
         key_n = 1'($urandom_range(0, 1));
         #(10 * $urandom_range(1, 12));
      end
      key_n = 1'b1; #400;
      check_eq("total_clicks", dut_clicks, m_clicks);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
